// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall unit: ID operand info, EX load info,
// MEM handshake, and the pipeline-register controls it drives back.
interface hazard_stall_unit_if;
  logic [4:0]  IdRs_i;
  logic [4:0]  IdRt_i;
  logic        IdUseRs_i;
  logic        IdUseRt_i;
  logic        ExMemRead_i;
  logic [4:0]  ExRegisterRt_i;
  logic        BranchTaken_i;
  logic        MemReq_i;
  logic        MemAck_i;
  logic        PcWrite_o;
  logic        IfIdWrite_o;
  logic        IfIdFlush_o;
  logic        IdExBubble_o;
  logic        PipeFreeze_o;
  logic        MemTimeout_o;
  logic [31:0] StallCycles_o;
  logic [15:0] FlushCount_o;

  modport master (
    output IdRs_i, IdRt_i, IdUseRs_i, IdUseRt_i, ExMemRead_i, ExRegisterRt_i,
           BranchTaken_i, MemReq_i, MemAck_i,
    input  PcWrite_o, IfIdWrite_o, IfIdFlush_o, IdExBubble_o, PipeFreeze_o,
           MemTimeout_o, StallCycles_o, FlushCount_o
  );

  modport slave (
    input  IdRs_i, IdRt_i, IdUseRs_i, IdUseRt_i, ExMemRead_i, ExRegisterRt_i,
           BranchTaken_i, MemReq_i, MemAck_i,
    output PcWrite_o, IfIdWrite_o, IfIdFlush_o, IdExBubble_o, PipeFreeze_o,
           MemTimeout_o, StallCycles_o, FlushCount_o
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use bubble, memory-wait freeze and branch flush control with a wait watchdog.
// Define HAZARD_PERF_EN to build the stall-cycle and flush performance counters.
//
// state   | meaning
// RUN     | no data-memory access pending from the previous cycle
// MEMWAIT | data-memory request outstanding, pipeline frozen, watchdog counting
module hazard_stall_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_e;

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       timeout_q;
  logic [8:0] wait_inc;

  logic mw, lu, rs_hit, rt_hit;
  logic freeze, bubble, flush, advance;

  assign mw     = hz.MemReq_i && !hz.MemAck_i;
  assign rs_hit = hz.IdUseRs_i && (hz.IdRs_i == hz.ExRegisterRt_i);
  assign rt_hit = hz.IdUseRt_i && (hz.IdRt_i == hz.ExRegisterRt_i);
  assign lu     = hz.ExMemRead_i && (hz.ExRegisterRt_i != 5'd0) && (rs_hit || rt_hit);

  // Freeze dominates load-use, which dominates the branch flush.
  assign freeze  = mw;
  assign bubble  = !mw && lu;
  assign advance = !mw && !lu;
  assign flush   = advance && hz.BranchTaken_i;

  assign hz.PipeFreeze_o = freeze;
  assign hz.IdExBubble_o = bubble;
  assign hz.PcWrite_o    = advance;
  assign hz.IfIdWrite_o  = advance;
  assign hz.IfIdFlush_o  = flush;
  assign hz.MemTimeout_o = timeout_q;

  assign wait_inc = {1'b0, wait_cnt_q} + 9'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          wait_cnt_q <= '0;
          if (mw) state_q <= MEMWAIT;
        end
        MEMWAIT: begin
          if (mw) begin
            if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_inc[7:0];
            // Sticky: the pipeline keeps waiting, only reset clears the flag.
            if (wait_inc == 9'(MAX_WAIT)) timeout_q <= 1'b1;
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((freeze || bubble) && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.StallCycles_o = stall_cnt_q;
  assign hz.FlushCount_o  = flush_cnt_q;
`else
  assign hz.StallCycles_o = 32'd0;
  assign hz.FlushCount_o  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: two units (MAX_WAIT=4 and 255) on the same stimulus,
// directed scenarios plus randomized traffic against a rule-level reference model.
module tb_hazard_stall_unit;
  localparam int MAXA = 4;
  localparam int MAXB = 255;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector order: {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze}
  localparam logic [4:0] C_NORM   = 5'b11000;
  localparam logic [4:0] C_FLUSH  = 5'b11100;
  localparam logic [4:0] C_BUBBLE = 5'b00010;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic use_rs, use_rt, ex_rd, br, req, ack;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_run;
  bit          m_to_a, m_to_b;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  always #5 clk = ~clk;

  hazard_stall_unit_if hz_a ();
  hazard_stall_unit_if hz_b ();

  assign hz_a.IdRs_i = id_rs;          assign hz_b.IdRs_i = id_rs;
  assign hz_a.IdRt_i = id_rt;          assign hz_b.IdRt_i = id_rt;
  assign hz_a.IdUseRs_i = use_rs;      assign hz_b.IdUseRs_i = use_rs;
  assign hz_a.IdUseRt_i = use_rt;      assign hz_b.IdUseRt_i = use_rt;
  assign hz_a.ExMemRead_i = ex_rd;     assign hz_b.ExMemRead_i = ex_rd;
  assign hz_a.ExRegisterRt_i = ex_rt;  assign hz_b.ExRegisterRt_i = ex_rt;
  assign hz_a.BranchTaken_i = br;      assign hz_b.BranchTaken_i = br;
  assign hz_a.MemReq_i = req;          assign hz_b.MemReq_i = req;
  assign hz_a.MemAck_i = ack;          assign hz_b.MemAck_i = ack;

  hazard_stall_unit #(.MAX_WAIT(MAXA)) u_dut_a (.clk_i(clk), .rst_i(rst), .hz(hz_a));
  hazard_stall_unit #(.MAX_WAIT(MAXB)) u_dut_b (.clk_i(clk), .rst_i(rst), .hz(hz_b));

  wire [4:0] ctrl_a = {hz_a.PcWrite_o, hz_a.IfIdWrite_o, hz_a.IfIdFlush_o, hz_a.IdExBubble_o, hz_a.PipeFreeze_o};
  wire [4:0] ctrl_b = {hz_b.PcWrite_o, hz_b.IfIdWrite_o, hz_b.IfIdFlush_o, hz_b.IdExBubble_o, hz_b.PipeFreeze_o};

  function automatic logic [4:0] exp_ctrl();
    bit mw, lu;
    mw = req && !ack;
    lu = ex_rd && ex_rt != 0 && ((use_rs && id_rs == ex_rt) || (use_rt && id_rt == ex_rt));
    if (mw)      return C_FREEZE;
    else if (lu) return C_BUBBLE;
    else if (br) return C_FLUSH;
    else         return C_NORM;
  endfunction

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    e = exp_ctrl();
    if (rst) begin
      m_run = 0; m_to_a = 0; m_to_b = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (e == C_FREEZE) begin
        if (m_run < 100000) m_run++;
        // Run of N consecutive waiting cycles holds N-1 counted MEMWAIT cycles.
        if (m_run > MAXA) m_to_a = 1;
        if (m_run > MAXB) m_to_b = 1;
      end else begin
        m_run = 0;
      end
      if (PERF) begin
        if ((e[0] || e[1]) && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (e[2] && m_flush != 16'hFFFF) m_flush++;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    use_rs = 0; use_rt = 0; ex_rd = 0; br = 0; req = 0; ack = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    set_idle();
    req = 1;
    rst = 1;
    tick(); tick();
    rst = 0; req = 0;
    @(negedge clk);
    checks++;
    if ({hz_a.MemTimeout_o, hz_b.MemTimeout_o} !== 2'b00) begin
      failures++; $display("FAIL reset_timeout got=%b exp=00", {hz_a.MemTimeout_o, hz_b.MemTimeout_o});
    end
    checks++;
    if ({hz_a.StallCycles_o, hz_a.FlushCount_o} !== 48'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hz_a.StallCycles_o, hz_a.FlushCount_o);
    end
    checks++;
    if (ctrl_a !== C_NORM) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_a, C_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_rd = 1; ex_rt = 5; id_rs = 5; use_rs = 1;
    @(negedge clk);
    checks++;
    if (ctrl_a !== C_BUBBLE) begin failures++; $display("FAIL lu_rs got=%b exp=%b", ctrl_a, C_BUBBLE); end
    use_rs = 0; id_rt = 5; use_rt = 1; #1;
    checks++;
    if (ctrl_a !== C_BUBBLE) begin failures++; $display("FAIL lu_rt got=%b exp=%b", ctrl_a, C_BUBBLE); end
    use_rt = 0; #1;
    checks++;
    if (ctrl_a !== C_NORM) begin failures++; $display("FAIL lu_unused got=%b exp=%b", ctrl_a, C_NORM); end
    id_rs = 5; use_rs = 1; ex_rt = 5'd21; #1;
    checks++;
    if (ctrl_a !== C_NORM) begin failures++; $display("FAIL lu_5bit got=%b exp=%b", ctrl_a, C_NORM); end
    ex_rt = 5; tick();
    ex_rd = 0;
    @(negedge clk);
    checks++;
    if (ctrl_a !== C_NORM) begin failures++; $display("FAIL lu_after got=%b exp=%b", ctrl_a, C_NORM); end
    ex_rd = 1; ex_rt = 0; id_rs = 0; id_rt = 0; use_rs = 1; use_rt = 1; #1;
    checks++;
    if (ctrl_a !== C_NORM) begin failures++; $display("FAIL lu_reg0 got=%b exp=%b", ctrl_a, C_NORM); end
    tick();
    set_idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    req = 1; ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctrl_a !== C_FREEZE) begin failures++; $display("FAIL mw_freeze cyc=%0d got=%b exp=%b", i, ctrl_a, C_FREEZE); end
      tick();
    end
    ack = 1;
    @(negedge clk);
    checks++;
    if (ctrl_a !== C_NORM) begin failures++; $display("FAIL mw_ack got=%b exp=%b", ctrl_a, C_NORM); end
    tick();
    req = 0; ack = 0;
    @(negedge clk);
    checks++;
    if (hz_a.StallCycles_o !== (PERF ? 32'd3 : 32'd0)) begin
      failures++; $display("FAIL mw_stallcnt got=%0d exp=%0d", hz_a.StallCycles_o, PERF ? 3 : 0);
    end
    checks++;
    if (hz_a.MemTimeout_o !== 1'b0) begin failures++; $display("FAIL mw_no_timeout got=%b exp=0", hz_a.MemTimeout_o); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1; ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (hz_a.MemTimeout_o !== (i >= 5)) begin
        failures++; $display("FAIL to_rise cyc=%0d got=%b exp=%b", i, hz_a.MemTimeout_o, (i >= 5));
      end
      tick();
    end
    ack = 1;
    @(negedge clk);
    checks++;
    if ({hz_a.MemTimeout_o, hz_b.MemTimeout_o, ctrl_a} !== {2'b10, C_NORM}) begin
      failures++; $display("FAIL to_at_ack got=%b exp=%b", {hz_a.MemTimeout_o, hz_b.MemTimeout_o, ctrl_a}, {2'b10, C_NORM});
    end
    tick();
    req = 0; ack = 0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (hz_a.MemTimeout_o !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", hz_a.MemTimeout_o); end
    do_reset();
    @(negedge clk);
    checks++;
    if (hz_a.MemTimeout_o !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", hz_a.MemTimeout_o); end
  endtask

  task automatic test_long_wait();
    do_reset();
    req = 1; ack = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      checks++;
      if (hz_b.MemTimeout_o !== (i >= 256)) begin
        failures++; $display("FAIL to255 cyc=%0d got=%b exp=%b", i, hz_b.MemTimeout_o, (i >= 256));
      end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_rd = 1; ex_rt = 7; id_rs = 7; use_rs = 1; br = 1;
    @(negedge clk);
    checks++;
    if (ctrl_a !== C_BUBBLE) begin failures++; $display("FAIL br_lu got=%b exp=%b", ctrl_a, C_BUBBLE); end
    tick();
    ex_rd = 0;
    @(negedge clk);
    checks++;
    if (ctrl_a !== C_FLUSH) begin failures++; $display("FAIL br_flush got=%b exp=%b", ctrl_a, C_FLUSH); end
    tick();
    req = 1; br = 1;
    @(negedge clk);
    checks++;
    if (ctrl_a !== C_FREEZE) begin failures++; $display("FAIL br_freeze got=%b exp=%b", ctrl_a, C_FREEZE); end
    checks++;
    if ({hz_a.FlushCount_o, hz_a.StallCycles_o} !== (PERF ? {16'd1, 32'd1} : 48'd0)) begin
      failures++; $display("FAIL br_counts got=%0d/%0d exp=%0d/%0d", hz_a.FlushCount_o, hz_a.StallCycles_o, PERF, PERF);
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_reset_midwait();
    do_reset();
    req = 1; ack = 0;
    tick(); tick(); tick();
    req = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({ctrl_a, hz_a.MemTimeout_o, hz_a.StallCycles_o, hz_a.FlushCount_o} !== {C_NORM, 1'b0, 48'd0}) begin
      failures++; $display("FAIL rst_midwait ctrl=%b to=%b stall=%0d flush=%0d exp ctrl=%b to=0 counts=0",
                           ctrl_a, hz_a.MemTimeout_o, hz_a.StallCycles_o, hz_a.FlushCount_o, C_NORM);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] e;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      id_rs  = 5'($urandom_range(0, 3));
      id_rt  = 5'($urandom_range(0, 3));
      ex_rt  = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom_range(0, 1));
      use_rt = 1'($urandom_range(0, 1));
      ex_rd  = 1'($urandom_range(0, 1));
      br     = 1'($urandom_range(0, 1));
      req    = ($urandom_range(0, 9) < 6);
      ack    = ($urandom_range(0, 9) < 3);
      rst    = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      e = exp_ctrl();
      checks++;
      if ({ctrl_a, ctrl_b} !== {e, e}) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got=%b/%b exp=%b", i, ctrl_a, ctrl_b, e);
      end
      checks++;
      if ({hz_a.MemTimeout_o, hz_b.MemTimeout_o} !== {m_to_a, m_to_b}) begin
        failures++; $display("FAIL rnd_timeout cyc=%0d got=%b%b exp=%b%b", i, hz_a.MemTimeout_o, hz_b.MemTimeout_o, m_to_a, m_to_b);
      end
      checks++;
      if ({hz_a.StallCycles_o, hz_a.FlushCount_o, hz_b.StallCycles_o, hz_b.FlushCount_o} !== {m_stall, m_flush, m_stall, m_flush}) begin
        failures++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, hz_a.StallCycles_o, hz_a.FlushCount_o, m_stall, m_flush);
      end
      tick();
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    m_run = 0; m_to_a = 0; m_to_b = 0; m_stall = '0; m_flush = '0;
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_long_wait();
    test_branch();
    test_reset_midwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Consumer-side counterpart of the ID-stage forwarding unit: where forwarding resolves RAW hazards by bypass, this block resolves the hazards forwarding cannot cover.
- **Load-use hazards:** inserts one bubble.
- **Multi-cycle data-memory accesses:** freezes the pipeline until the request/acknowledge handshake completes.
- **Taken branches resolved in ID:** flushes IF/ID.

It sits beside the forwarding unit in ID and drives the PC, IF/ID and ID/EX pipeline-register controls. It also keeps a memory-wait watchdog and optional performance counters.

## Interface
Parameters:
- MAX_WAIT, 255: memory-wait cycles before the watchdog fires; legal range 1..255.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- IdRs_i  in  5  rs of instruction in ID.
- IdRt_i  in  5  rt of instruction in ID.
- IdUseRs_i  in  1  ID instruction reads rs.
- IdUseRt_i  in  1  ID instruction reads rt.
- ExMemRead_i  in  1  instruction in EX is a load.
- ExRegisterRt_i  in  5  load destination in EX.
- BranchTaken_i  in  1  branch in ID resolved taken.
- MemReq_i  in  1  MEM stage has an outstanding data-memory request.
- MemAck_i  in  1  data memory completes the request this cycle.
- PcWrite_o  out  1  PC may update.
- IfIdWrite_o  out  1  IF/ID may update.
- IfIdFlush_o  out  1  IF/ID loads a NOP.
- IdExBubble_o  out  1  ID/EX loads control zeros.
- PipeFreeze_o  out  1  ID/EX, EX/MEM and MEM/WB hold.
- MemTimeout_o  out  1  sticky watchdog flag.
- StallCycles_o  out  32  stall-cycle counter (see Configuration).
- FlushCount_o  out  16  flush counter (see Configuration).

## Operation
- **Load-use condition (LU):** ExMemRead_i && ExRegisterRt_i != 0 && ((IdUseRs_i && IdRs_i == ExRegisterRt_i) || (IdUseRt_i && IdRt_i == ExRegisterRt_i)).
- **Memory-wait condition (MW):** MemReq_i && !MemAck_i.
- **FSM:** two states, RUN and MEMWAIT.
  - RUN→MEMWAIT when MW.
  - MEMWAIT→RUN when MemAck_i.
  - MEMWAIT stays while MW.
  - MEMWAIT with MemReq_i=0 returns to RUN; this is a protocol error and is not flagged.
- **Output priority:** freeze > load-use > flush.
  - **Freeze (MW true, any state):** PipeFreeze_o=1, PcWrite_o=0, IfIdWrite_o=0, IdExBubble_o=0, IfIdFlush_o=0.
  - **Else LU:** PcWrite_o=0, IfIdWrite_o=0, IdExBubble_o=1, IfIdFlush_o=0. The branch in ID is re-evaluated next cycle.
  - **Else BranchTaken_i:** IfIdFlush_o=1, PcWrite_o=1, IfIdWrite_o=1.
  - **Otherwise:** PcWrite_o=1, IfIdWrite_o=1, all others 0.
- **Wait counter:** 8-bit.
  - Cleared on entry to MEMWAIT and in RUN.
  - Increments each cycle in MEMWAIT with MW; saturates at 255.
  - When it reaches MAX_WAIT, MemTimeout_o sets. It stays set until rst_i; the pipeline keeps waiting.
- Rs/Rt equality uses all 5 bits; register 0 never hazards.

## Timing
- Control outputs are combinational from inputs and state, valid in the same cycle.
- **Load-use:** exactly one bubble per load, because the load advances to MEM next cycle and LU clears.
- **Memory access:** a request acknowledged in its first cycle costs zero stall cycles. A request acknowledged N cycles after issue freezes the pipeline for N cycles.
- **Simultaneous events:**
  - LU and MW in the same cycle: freeze only, with no bubble. The LU is re-detected after the freeze.
  - BranchTaken_i during freeze or LU: no flush that cycle.
- **Reset values, on the cycle after rst_i is sampled high:**
  - State RUN, wait counter 0.
  - MemTimeout_o=0, StallCycles_o=0, FlushCount_o=0.
  - Combinational outputs follow the inputs immediately.
- **Reset mid-MEMWAIT:** the block returns to RUN. Any freeze after reset comes only from the current MW.

## Configuration
- **HAZARD_PERF_EN defined:**
  - StallCycles_o increments, saturating, on every cycle with PipeFreeze_o or IdExBubble_o.
  - FlushCount_o increments, saturating, on every cycle with IfIdFlush_o.
- **Undefined:** both ports are tied to 0 and no counter flops exist.

## Test plan
- Load to $5 in EX, ID reads rs=$5 with IdUseRs_i=1 → one cycle of PcWrite_o=0, IdExBubble_o=1; next cycle (EX no longer a load) normal flow.
- Load to $0 in EX, ID reads $0 → no stall; PcWrite_o=1.
- MemReq_i high, MemAck_i on the 4th cycle → PipeFreeze_o=1 for 3 cycles, state MEMWAIT for 3 cycles, then RUN; StallCycles_o=3 with HAZARD_PERF_EN.
- MAX_WAIT=4, MemReq_i held high with no ack for 6 cycles → MemTimeout_o rises after the 4th wait cycle, stays 1 after the ack, clears only on rst_i.
- BranchTaken_i=1 together with LU → bubble only, IfIdFlush_o=0; next cycle BranchTaken_i=1 alone → IfIdFlush_o=1, FlushCount_o=1.
- rst_i asserted mid-MEMWAIT with MemReq_i=0 → next cycle state RUN, all counters and MemTimeout_o 0, PcWrite_o=1.
